// File: rtl/decodificador_multicanal_pkg.sv
// Shared command/response codes, FSM states and frame layout for the multichannel DHT11 decoder.
package decodificador_pkg;

  localparam logic [7:0] CMD_STATUS    = 8'h03;
  localparam logic [7:0] CMD_TEMP      = 8'h04;
  localparam logic [7:0] CMD_HUM       = 8'h05;
  localparam logic [7:0] CMD_CONT_TEMP = 8'h06;
  localparam logic [7:0] CMD_CONT_HUM  = 8'h07;
  localparam logic [7:0] CMD_STOP      = 8'h08;

  localparam logic [7:0] RESP_OK          = 8'h00;
  localparam logic [7:0] RESP_ERRO_SENSOR = 8'h1F;
  localparam logic [7:0] RESP_CMD_INV     = 8'h0A;
  localparam logic [7:0] RESP_CANAL_INV   = 8'h0B;
  localparam logic [7:0] RESP_SEM_DADO    = 8'h0C;
  localparam logic [7:0] RESP_ACK_CONT    = 8'h0D;
  localparam logic [7:0] RESP_ACK_STOP    = 8'h0E;

  // Byte positions inside a frame word; HUM_INT occupies the MSBs.
  localparam int IDX_HUM_INT    = 4;
  localparam int IDX_HUM_FLOAT  = 3;
  localparam int IDX_TEMP_INT   = 2;
  localparam int IDX_TEMP_FLOAT = 1;
  localparam int IDX_CRC        = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SEND1,
    ST_SEND2
  } estado_t;

  function automatic logic canal_valido(input logic [7:0] canal, input int n_canais);
    return int'({24'd0, canal}) < n_canais;
  endfunction

endpackage

// File: rtl/decodificador_multicanal_verificador_crc.sv
// Combinational DHT11 checksum compare: sum of the four data bytes, modulo 2^DATA_W, against CRC.
module verificador_crc
  import decodificador_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [5*DATA_W-1:0] frame,
  output logic                crc_ok
);

  localparam logic [DATA_W+1:0] MASCARA = {2'b00, {DATA_W{1'b1}}};

  logic [DATA_W+1:0] soma;

  assign soma = {2'b00, frame[IDX_HUM_INT*DATA_W +: DATA_W]}
              + {2'b00, frame[IDX_HUM_FLOAT*DATA_W +: DATA_W]}
              + {2'b00, frame[IDX_TEMP_INT*DATA_W +: DATA_W]}
              + {2'b00, frame[IDX_TEMP_FLOAT*DATA_W +: DATA_W]};

  // Carry bits are masked away so the compare is the 8-bit-wrap checksum.
  assign crc_ok = ((soma ^ {2'b00, frame[IDX_CRC*DATA_W +: DATA_W]}) & MASCARA) == '0;

endmodule

// File: rtl/decodificador_multicanal.sv
// Multichannel DHT11 command decoder: per-channel frame store, command FSM and periodic reports.
module decodificador_multicanal
  import decodificador_pkg::*;
#(
  parameter int N_CANAIS = 32,
  parameter int DATA_W   = 8,
  parameter int PERIODO  = 50_000_000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                frame_valid,
  input  logic [7:0]          frame_canal,
  input  logic [5*DATA_W-1:0] frame_dados,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_cmd,
  input  logic [7:0]          req_canal,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_dados,
  output logic                resp_last
);

  localparam int IDX_W   = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
  localparam int CNT_W   = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int FRAME_W = 5 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIODO - 1);

  logic [FRAME_W-1:0]  mem [N_CANAIS];
  logic [FRAME_W-1:0]  snap_q;

  estado_t             estado_q, estado_d;
  logic [N_CANAIS-1:0] presente_q, presente_d;
  logic [7:0]          cmd_q, cmd_d, canal_q, canal_d;
  logic                pres_snap_q, pres_snap_d;
  logic [DATA_W-1:0]   byte1_q, byte1_d, byte2_q, byte2_d;
  logic                dois_q, dois_d;
  logic                req_ready_q, req_ready_d;
  logic                cont_on_q, cont_on_d, cont_hum_q, cont_hum_d;
  logic [7:0]          cont_canal_q, cont_canal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;

  logic                aceita, dispara, rd_en, wr_en, tick, crc_ok;
  logic [7:0]          rd_canal;
  logic [IDX_W-1:0]    rd_idx, wr_idx;
  logic [DATA_W-1:0]   byte_int, byte_float;

  verificador_crc #(.DATA_W(DATA_W)) u_crc (
    .frame  (snap_q),
    .crc_ok (crc_ok)
  );

  always_comb begin
    aceita   = req_valid && req_ready_q;
    dispara  = req_ready_q && !req_valid && pend_q;
    rd_en    = aceita || dispara;
    rd_canal = aceita ? req_canal : cont_canal_q;
    rd_idx   = canal_valido(rd_canal, N_CANAIS) ? rd_canal[IDX_W-1:0] : '0;
    wr_en    = frame_valid && canal_valido(frame_canal, N_CANAIS);
    wr_idx   = frame_canal[IDX_W-1:0];
  end

  // Registered read: a write landing on the same edge is not seen by the snapshot.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= frame_dados;
    if (rd_en) snap_q <= mem[rd_idx];
  end

  assign byte_int   = (cmd_q == CMD_HUM) ? snap_q[IDX_HUM_INT*DATA_W +: DATA_W]
                                         : snap_q[IDX_TEMP_INT*DATA_W +: DATA_W];
  assign byte_float = (cmd_q == CMD_HUM) ? snap_q[IDX_HUM_FLOAT*DATA_W +: DATA_W]
                                         : snap_q[IDX_TEMP_FLOAT*DATA_W +: DATA_W];

  always_comb begin
    estado_d     = estado_q;
    presente_d   = presente_q;
    cmd_d        = cmd_q;
    canal_d      = canal_q;
    pres_snap_d  = pres_snap_q;
    byte1_d      = byte1_q;
    byte2_d      = byte2_q;
    dois_d       = dois_q;
    cont_on_d    = cont_on_q;
    cont_hum_d   = cont_hum_q;
    cont_canal_d = cont_canal_q;

    if (wr_en) presente_d[wr_idx] = 1'b1;
    if (rd_en) pres_snap_d = canal_valido(rd_canal, N_CANAIS) && presente_q[rd_idx];

    // Ticks while a report is outstanding merge into the single pending flag.
    tick   = cont_on_q && (cnt_q == CNT_MAX);
    cnt_d  = cont_on_q ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
    pend_d = pend_q | tick;

    unique case (estado_q)
      ST_IDLE: begin
        if (aceita) begin
          cmd_d    = req_cmd;
          canal_d  = req_canal;
          estado_d = ST_DECODE;
        end else if (dispara) begin
          cmd_d    = cont_hum_q ? CMD_HUM : CMD_TEMP;
          canal_d  = cont_canal_q;
          pend_d   = tick;
          estado_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        estado_d = ST_SEND1;
        dois_d   = 1'b0;
        byte2_d  = byte_float;
        if (cmd_q < CMD_STATUS || cmd_q > CMD_STOP) begin
          byte1_d = DATA_W'(RESP_CMD_INV);
        end else if (cmd_q == CMD_STOP) begin
          byte1_d   = DATA_W'(RESP_ACK_STOP);
          cont_on_d = 1'b0;
          cnt_d     = '0;
          pend_d    = 1'b0;
        end else if (!canal_valido(canal_q, N_CANAIS)) begin
          byte1_d = DATA_W'(RESP_CANAL_INV);
        end else if (!pres_snap_q) begin
          byte1_d = DATA_W'(RESP_SEM_DADO);
        end else if (cmd_q == CMD_STATUS) begin
          byte1_d = crc_ok ? DATA_W'(RESP_OK) : DATA_W'(RESP_ERRO_SENSOR);
        end else if (cmd_q == CMD_TEMP || cmd_q == CMD_HUM) begin
          byte1_d = crc_ok ? byte_int : DATA_W'(RESP_ERRO_SENSOR);
          dois_d  = crc_ok;
        end else begin
          byte1_d      = DATA_W'(RESP_ACK_CONT);
          cont_on_d    = 1'b1;
          cont_hum_d   = (cmd_q == CMD_CONT_HUM);
          cont_canal_d = canal_q;
          cnt_d        = '0;
          pend_d       = 1'b0;
        end
      end
      ST_SEND1: begin
        if (resp_ready) estado_d = dois_q ? ST_SEND2 : ST_IDLE;
      end
      ST_SEND2: begin
        if (resp_ready) estado_d = ST_IDLE;
      end
      default: estado_d = ST_IDLE;
    endcase

    req_ready_d = (estado_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= ST_IDLE;
      presente_q   <= '0;
      cmd_q        <= '0;
      canal_q      <= '0;
      pres_snap_q  <= 1'b0;
      byte1_q      <= '0;
      byte2_q      <= '0;
      dois_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      cont_on_q    <= 1'b0;
      cont_hum_q   <= 1'b0;
      cont_canal_q <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      presente_q   <= presente_d;
      cmd_q        <= cmd_d;
      canal_q      <= canal_d;
      pres_snap_q  <= pres_snap_d;
      byte1_q      <= byte1_d;
      byte2_q      <= byte2_d;
      dois_q       <= dois_d;
      req_ready_q  <= req_ready_d;
      cont_on_q    <= cont_on_d;
      cont_hum_q   <= cont_hum_d;
      cont_canal_q <= cont_canal_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = (estado_q == ST_SEND1) || (estado_q == ST_SEND2);
  assign resp_dados = (estado_q == ST_SEND1) ? byte1_q :
                      (estado_q == ST_SEND2) ? byte2_q : '0;
  assign resp_last  = ((estado_q == ST_SEND1) && !dois_q) || (estado_q == ST_SEND2);

endmodule

// File: doc/decodificador_multicanal.md
Name: decodificador_multicanal

Overview:
Parametrised successor to the single-sensor command decoder. It stores the latest 5-byte DHT11 frame per channel (humidity int/float, temperature int/float, checksum), decodes commands from the UART receive path and emits one- or two-byte responses to the UART transmit path over a valid/ready handshake. It adds checksum verification with 8-bit wrap, per-channel presence tracking, error codes and a periodic continuous-report mode. It sits between the UART RX/TX blocks and the sensor reader(s).

Parameters:
N_CANAIS, 32, number of sensor channels (1..256)
DATA_W, 8, width of each sensor byte and response byte
PERIODO, 50_000_000, continuous-mode report interval in clock cycles (>=4)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
frame_valid  in  1  one-cycle strobe: new frame for frame_canal
frame_canal  in  8  channel of incoming frame
frame_dados  in  5*DATA_W  {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC}, HUM_INT in MSBs
req_valid  in  1  command available
req_ready  out  1  decoder can accept command
req_cmd  in  8  command code
req_canal  in  8  target channel
resp_valid  out  1  response byte valid
resp_ready  in  1  TX accepts byte
resp_dados  out  DATA_W  response byte
resp_last  out  1  marks final byte of a response

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM IDLE; all channel-present bits 0; continuous mode off; period counter 0. Frame storage need not be cleared.
- Frame write: on frame_valid with frame_canal<N_CANAIS, store frame, set present bit; frame_canal>=N_CANAIS ignored. Writes proceed in every FSM state.
- Commands: 0x03 status, 0x04 temperature, 0x05 humidity, 0x06 start continuous temperature, 0x07 start continuous humidity, 0x08 stop continuous.
- Handshake: req_ready=1 only in IDLE. Command accepted when req_valid&&req_ready; req_cmd/req_canal and that channel's frame snapshot latched the same edge. A frame write to the same channel in the accept cycle is NOT visible in the snapshot.
- FSM: IDLE -> DECODE (1 cycle) -> SEND1 -> [SEND2] -> IDLE. resp_valid rises the cycle after DECODE; byte held stable until resp_valid&&resp_ready; no bubble between SEND1 and SEND2.
- Checksum: ok iff (HUM_INT+HUM_FLOAT+TEMP_INT+TEMP_FLOAT) mod 2^DATA_W == CRC; sum computed at DATA_W+2 bits then truncated.
- Response rules (priority order):
  - cmd not in 0x03..0x08 -> 1 byte 0x0A.
  - canal>=N_CANAIS (cmds 0x03..0x07) -> 1 byte 0x0B.
  - present bit 0 (0x03..0x07) -> 1 byte 0x0C.
  - 0x03 -> 1 byte 0x00 if checksum ok else 0x1F.
  - 0x04/0x05 with bad checksum -> 1 byte 0x1F; else 2 bytes INT then FLOAT, resp_last on second.
  - 0x06/0x07 -> set continuous channel/quantity, period counter cleared, 1 byte 0x0D ack. 0x08 -> clear mode, 1 byte 0x0E (also when already off).
- Continuous mode: period counter counts 0..PERIODO-1 while mode on, wraps, raising pending flag at wrap. When IDLE, pending set and req_valid=0: snapshot configured channel, clear pending, respond as 0x04/0x05 would. req_valid has priority; pending persists (max one outstanding, extra ticks dropped).
- resp_ready low indefinitely: FSM stalls; frames still stored; period ticks coalesce into the single pending flag.
- Reset mid-response: response aborted, resp_valid drops asynchronously.

Decomposition:
- Package decodificador_pkg: command codes (CMD_STATUS=3, CMD_TEMP=4, CMD_HUM=5, CMD_CONT_TEMP=6, CMD_CONT_HUM=7, CMD_STOP=8), response codes (RESP_OK=0x00, RESP_ERRO_SENSOR=0x1F, RESP_CMD_INV=0x0A, RESP_CANAL_INV=0x0B, RESP_SEM_DADO=0x0C, RESP_ACK_CONT=0x0D, RESP_ACK_STOP=0x0E), FSM state enum, frame byte-index constants.
- Sub-module: verificador_crc (combinational DATA_W-generic checksum compare), instantiated once on the snapshot.

Test Plan:
- Frame {0x3C,0x00,0x19,0x05,0x5A} to ch 2, cmd 0x04 ch 2, resp_ready=1 -> bytes 0x19, 0x05; resp_last on 0x05; req_ready low until done.
- Frame {0x3C,0x00,0x19,0x05,0x00} to ch 2, cmd 0x03 -> single 0x1F; cmd 0x05 -> single 0x1F. Frame {0xFF,0xFF,0x01,0x01,0x00} -> 0x03 gives 0x00 (wrap).
- After reset, cmd 0x05 ch 0 -> 0x0C; cmd 0x04 ch N_CANAIS -> 0x0B; cmd 0x09 -> 0x0A.
- PERIODO=16: cmd 0x07 ch 1 -> 0x0D, then HUM_INT/HUM_FLOAT pairs every 16 cycles; cmd 0x08 -> 0x0E, no further reports.
- resp_ready=0 for 40 cycles during SEND1 -> byte held stable, no extra bytes; frame writes and at most one pending report preserved.
- Frame write to ch 3 in same cycle as cmd 0x04 ch 3 accepted -> old values returned; next 0x04 returns new values.
